pool_flatten_streamer: RTL
==========================

// Module: pool_flatten_streamer
// PURPOSE
//  Downstream of the 2x2 max-pool stage. Captures one pooled frame (CI x P_SIZE x P_SIZE
//  signed elements, presented as one wide word with a 1-cycle valid) and flattens it.
//  Emits the frame one element per beat over a valid/ready stream to the fully-connected
//  layer. Pool output has no backpressure, so this block is the buffering/rate-adapt point.
// PARAMETERS
//  CI      3   channels per pooled frame
//  P_SIZE  4   pooled map width = height
//  OF_BW   16  element width, signed two's complement
//  N       CI*P_SIZE*P_SIZE (localparam, 48); IDX_BW = $clog2(N) (localparam, 6)
// PORTS
//  clk          in   1            clock, rising edge
//  reset_n      in   1            async active-low reset
//  i_in_valid   in   1            1-cycle pulse: i_in_fmap holds a full pooled frame
//  i_in_fmap    in   N*OF_BW      element k at [OF_BW*k +: OF_BW], k=(ci*P_SIZE+row)*P_SIZE+col
//  o_in_ready   out  1            combinational: frame would be accepted this cycle
//  o_ot_valid   out  1            output beat valid
//  o_ot_data    out  OF_BW        current element, bit-exact copy of captured element
//  o_ot_idx     out  IDX_BW       flat index k of current element
//  o_ot_last    out  1            high with beat k = N-1
//  i_ot_ready   in   1            consumer accepts beat when o_ot_valid & i_ot_ready
//  o_drop_cnt   out  8            frames lost (arrived while not ready), saturates at 255
// BEHAVIOUR
//  Reset: state IDLE, frame buffer 0, o_ot_valid=0, o_ot_data=0, o_ot_idx=0, o_ot_last=0,
//   o_drop_cnt=0. Async assert, no flush; reset mid-frame aborts frame, nothing resumes.
//  FSM: IDLE -> STREAM on accepted frame; STREAM -> IDLE on handshake of beat N-1 unless
//   a new frame is accepted the same cycle (then stay STREAM, restart at k=0).
//  o_in_ready = (state==IDLE) | (state==STREAM & o_ot_last & i_ot_ready).
//  Accept (i_in_valid & o_in_ready) at edge T: buffer <- i_in_fmap, k <- 0; from T+1
//   o_ot_valid=1, o_ot_data=element 0, o_ot_idx=0. Latency 1 cycle, no bubbles when
//   i_ot_ready held high: beat k appears at T+1+k, N beats back-to-back.
//  Handshake at edge with k<N-1: k <- k+1. At k=N-1: o_ot_valid falls next cycle unless new frame
//   accepted same edge (then next cycle shows new element 0, zero bubble between frames).
//  Stall: while o_ot_valid & !i_ot_ready, o_ot_data/o_ot_idx/o_ot_last hold stable; o_ot_valid
//   never drops without a handshake.
//  Drop: i_in_valid & !o_in_ready -> frame discarded, buffer and stream untouched,
//   o_drop_cnt increments next edge (saturating at 255).
//  o_ot_last = o_ot_valid & (o_ot_idx == N-1). All outputs registered except o_in_ready.
//  No arithmetic on data: signedness only matters for the bench (negatives pass unchanged).
// TESTING
//  1 frame, elem k = k+1, i_ot_ready=1 -> 48 beats from T+1, data 1..48, idx 0..47, last only on 47.
//  Same frame, i_ot_ready toggling 1,0,0,1... -> data/idx held while stalled, no beat lost/duplicated.
//  Frame B pulsed exactly on beat-47 handshake of frame A -> B elem 0 next cycle, no gap, drop_cnt=0.
//  Frame pulsed while streaming beat 10 -> ignored, o_drop_cnt=1, current frame completes intact.
//  Assert reset_n at beat 20 -> all outputs 0 immediately; after release a new frame streams from idx 0.
//  Elements 16'h8000,16'hFFFF,16'h7FFF -> emitted bit-exact; 300 drops -> o_drop_cnt stays 255.

Source files
------------

// File: rtl/pool_flatten_streamer.sv
// pool_flatten_streamer: buffers one pooled frame and streams it out one element per beat.
//
// Ports:
//   clk, reset_n  rising-edge clock, asynchronous active-low reset
//   i_in_valid    1-cycle pulse; i_in_fmap carries a full pooled frame
//   i_in_fmap     N elements, element k at [OF_BW*k +: OF_BW], k = (ci*P_SIZE+row)*P_SIZE+col
//   o_in_ready    combinational; a frame presented this cycle would be accepted
//   o_ot_valid    output beat valid
//   o_ot_data     current element, bit-exact copy of the captured element
//   o_ot_idx      flat index k of the current element
//   o_ot_last     high on beat k = N-1
//   i_ot_ready    consumer accepts the beat when o_ot_valid & i_ot_ready
//   o_drop_cnt    frames lost while not ready, saturating at 255
module pool_flatten_streamer #(
    parameter  int CI     = 3,
    parameter  int P_SIZE = 4,
    parameter  int OF_BW  = 16,
    localparam int N      = CI * P_SIZE * P_SIZE,
    localparam int IDX_BW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_in_valid,
    input  logic [N*OF_BW-1:0]    i_in_fmap,
    output logic                  o_in_ready,
    output logic                  o_ot_valid,
    output logic [OF_BW-1:0]      o_ot_data,
    output logic [IDX_BW-1:0]     o_ot_idx,
    output logic                  o_ot_last,
    input  logic                  i_ot_ready,
    output logic [7:0]            o_drop_cnt
);
    localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(N - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state, state_n;
    logic [OF_BW-1:0]    frame_buf [N];
    logic                accept, hs, advance;
    logic [IDX_BW-1:0]   idx_inc, idx_n;
    logic [OF_BW-1:0]    data_n;
    logic                valid_n, last_n;

    // A new frame may land on the very edge that retires the final beat, giving zero bubbles.
    assign o_in_ready = (state == IDLE) | ((state == STREAM) & o_ot_last & i_ot_ready);
    assign accept     = i_in_valid & o_in_ready;
    assign hs         = o_ot_valid & i_ot_ready;
    assign advance    = hs & !o_ot_last;
    assign idx_inc    = o_ot_idx + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = accept ? STREAM : (hs & o_ot_last) ? IDLE : state;
    end

    // Next values of the registered stream outputs; element 0 bypasses the buffer on accept.
    always_comb begin
        idx_n   = accept ? '0 : advance ? idx_inc : o_ot_idx;
        data_n  = accept ? i_in_fmap[OF_BW-1:0] : advance ? frame_buf[idx_inc] : o_ot_data;
        valid_n = (state_n == STREAM);
        last_n  = valid_n & (idx_n == LAST_IDX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_ot_valid <= 1'b0;
            o_ot_data  <= '0;
            o_ot_idx   <= '0;
            o_ot_last  <= 1'b0;
        end else begin
            o_ot_valid <= valid_n;
            o_ot_data  <= data_n;
            o_ot_idx   <= idx_n;
            o_ot_last  <= last_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++)
                frame_buf[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < N; i++)
                frame_buf[i] <= i_in_fmap[OF_BW*i +: OF_BW];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            o_drop_cnt <= '0;
        else if (i_in_valid & !o_in_ready & (o_drop_cnt != 8'hFF))
            o_drop_cnt <= o_drop_cnt + 8'd1;
    end
endmodule
